// File: rtl/tilemap_loader_pkg.sv
// tilemap_loader_pkg: tile types, screen geometry, loader FSM states and the
// logical-to-physical column mapping used by every reader of the tile map.
package tilemap_loader_pkg;
    typedef logic [2:0] tile_t;
    localparam tile_t TILE_EMPTY = 3'b000;
    localparam tile_t TILE_SOLID = 3'b111;
    localparam int ROWS = 15;
    localparam int COLS = 20;
    localparam int LEVEL_COLS = 212;
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [4:0] COL_LAST = 5'(COLS - 1);
    localparam logic [7:0] VIEW_MAX = 8'(LEVEL_COLS - COLS);
    typedef enum logic [1:0] {IDLE, LOAD, SCROLL, ACK} loader_state_t;
    // The map is a circular buffer of columns; head is the physical column
    // holding logical screen column 0. Only valid for col < COLS.
    function automatic logic [4:0] phys_col(input logic [4:0] col, input logic [4:0] head);
        logic [5:0] sum;
        sum = {1'b0, col} + {1'b0, head};
        return (sum >= 6'(COLS)) ? 5'(sum - 6'(COLS)) : sum[4:0];
    endfunction
endpackage

// File: rtl/tilemap_loader_if.sv
// tilemap_loader_if: bundle of the loader's request/status handshake, level
// ROM bus and the two combinational read ports.
//   master: requester / ROM / readers side   slave: tilemap_loader side
interface tilemap_loader_if;
    import tilemap_loader_pkg::*;
    logic       load_start;
    logic       scroll_req;
    logic       busy;
    logic       scroll_ack;
    logic       at_end;
    logic [7:0] view_col;
    logic [7:0] rom_col;
    logic [3:0] rom_row;
    tile_t      rom_data;
    logic [3:0] pix_row;
    logic [4:0] pix_col;
    tile_t      pix_tile;
    logic [3:0] cl_row;
    logic [4:0] cl_col;
    tile_t      cl_tile;
    modport master (
        output load_start, scroll_req, rom_data, pix_row, pix_col, cl_row, cl_col,
        input  busy, scroll_ack, at_end, view_col, rom_col, rom_row, pix_tile, cl_tile
    );
    modport slave (
        input  load_start, scroll_req, rom_data, pix_row, pix_col, cl_row, cl_col,
        output busy, scroll_ack, at_end, view_col, rom_col, rom_row, pix_tile, cl_tile
    );
endinterface

// File: rtl/tilemap_loader_store.sv
// tilemap_loader_store: 15x20 physical tile array with one write port and two
// zero-latency read ports addressed in logical (scrolled) columns.
//   clk_i/rst_ni        clock, async active-low reset (clears map to TILE_EMPTY)
//   we_i/wr_row_i/wr_col_i/wr_data_i   physical write port
//   head_i              physical column of logical column 0
//   pix_*/cl_*          logical read ports; out-of-range reads give TILE_SOLID
module tilemap_loader_store
    import tilemap_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we_i,
    input  logic [3:0] wr_row_i,
    input  logic [4:0] wr_col_i,
    input  tile_t      wr_data_i,
    input  logic [4:0] head_i,
    input  logic [3:0] pix_row_i,
    input  logic [4:0] pix_col_i,
    output tile_t      pix_tile_o,
    input  logic [3:0] cl_row_i,
    input  logic [4:0] cl_col_i,
    output tile_t      cl_tile_o
);
    tile_t tiles_q [ROWS][COLS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    tiles_q[r][c] <= TILE_EMPTY;
        end else if (we_i) begin
            tiles_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    assign pix_tile_o = (pix_row_i > ROW_LAST || pix_col_i > COL_LAST) ? TILE_SOLID
                      : tiles_q[pix_row_i][phys_col(pix_col_i, head_i)];
    assign cl_tile_o  = (cl_row_i > ROW_LAST || cl_col_i > COL_LAST) ? TILE_SOLID
                      : tiles_q[cl_row_i][phys_col(cl_col_i, head_i)];
endmodule

// File: rtl/tilemap_loader.sv
// tilemap_loader: fills the on-screen tile map from the level ROM on a load
// request and replaces one column of the circular buffer per scroll request.
//   clk_i/rst_ni  clock, async active-low reset
//   bus           tilemap_loader_if.slave: load_start/scroll_req in,
//                 busy/scroll_ack/at_end/view_col out, ROM address out and
//                 rom_data in (1-cycle latency), pix_* and cl_* read ports
module tilemap_loader
    import tilemap_loader_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    tilemap_loader_if.slave bus
);
    loader_state_t state_q, state_d;
    logic       iss_q, iss_d;
    logic       wr_en_q, wr_en_d;
    logic       wr_last_q, wr_last_d;
    logic [3:0] rom_row_q, rom_row_d;
    logic [7:0] rom_col_q, rom_col_d;
    logic [3:0] wr_row_q, wr_row_d;
    logic [4:0] wr_col_q, wr_col_d;
    logic [4:0] head_q, head_d;
    logic [7:0] view_col_q, view_col_d;
    logic       at_end;

    assign at_end = view_col_q == VIEW_MAX;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            iss_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_last_q  <= 1'b0;
            rom_row_q  <= '0;
            rom_col_q  <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            head_q     <= '0;
            view_col_q <= '0;
        end else begin
            state_q    <= state_d;
            iss_q      <= iss_d;
            wr_en_q    <= wr_en_d;
            wr_last_q  <= wr_last_d;
            rom_row_q  <= rom_row_d;
            rom_col_q  <= rom_col_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            head_q     <= head_d;
            view_col_q <= view_col_d;
        end
    end

    // iss_q: an address is being presented to the ROM this cycle.
    // wr_*_q: the address presented last cycle, whose data is on rom_data now.
    always_comb begin
        state_d    = state_q;
        iss_d      = iss_q;
        wr_en_d    = 1'b0;
        wr_last_d  = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        rom_row_d  = rom_row_q;
        rom_col_d  = rom_col_q;
        head_d     = head_q;
        view_col_d = view_col_q;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d    = LOAD;
                    iss_d      = 1'b1;
                    head_d     = '0;
                    view_col_d = '0;
                    rom_col_d  = '0;
                    rom_row_d  = '0;
                end else if (bus.scroll_req) begin
                    state_d   = at_end ? ACK : SCROLL;
                    iss_d     = !at_end;
                    rom_col_d = at_end ? rom_col_q : view_col_q + 8'(COLS);
                    rom_row_d = at_end ? rom_row_q : 4'd0;
                end
            end
            LOAD, SCROLL: begin
                if (iss_q) begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = rom_row_q;
                    // During a load head is 0, so the logical column is physical.
                    wr_col_d  = (state_q == LOAD) ? rom_col_q[4:0] : head_q;
                    wr_last_d = rom_row_q == ROW_LAST && (state_q == SCROLL || rom_col_q == 8'(COL_LAST));
                    rom_row_d = (rom_row_q == ROW_LAST) ? 4'd0 : rom_row_q + 4'd1;
                    rom_col_d = (state_q == LOAD && rom_row_q == ROW_LAST) ? rom_col_q + 8'd1 : rom_col_q;
                    iss_d     = !wr_last_d;
                end
                if (wr_en_q && wr_last_q) begin
                    state_d    = (state_q == LOAD) ? IDLE : ACK;
                    head_d     = (state_q == SCROLL) ? ((head_q == COL_LAST) ? 5'd0 : head_q + 5'd1) : head_q;
                    view_col_d = (state_q == SCROLL) ? view_col_q + 8'd1 : view_col_q;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = state_q != IDLE;
    assign bus.scroll_ack = state_q == ACK;
    assign bus.at_end     = at_end;
    assign bus.view_col   = view_col_q;
    assign bus.rom_col    = rom_col_q;
    assign bus.rom_row    = rom_row_q;

    tilemap_loader_store u_store (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we_i       (wr_en_q),
        .wr_row_i   (wr_row_q),
        .wr_col_i   (wr_col_q),
        .wr_data_i  (bus.rom_data),
        .head_i     (head_q),
        .pix_row_i  (bus.pix_row),
        .pix_col_i  (bus.pix_col),
        .pix_tile_o (bus.pix_tile),
        .cl_row_i   (bus.cl_row),
        .cl_col_i   (bus.cl_col),
        .cl_tile_o  (bus.cl_tile)
    );
endmodule

// File: tb/tb_tilemap_loader.sv
// tb_tilemap_loader: scoreboard bench for tilemap_loader with a col^row level ROM model.
module tb_tilemap_loader;
    import tilemap_loader_pkg::*;

    typedef struct {
        int busy_n;
        int ack_at;
        int acks;
        int view;
    } exp_t;

    logic clk;
    logic rst_n;
    int checks;
    int errors;
    int model_view;
    exp_t sb_q[$];

    tilemap_loader_if bus();

    tilemap_loader dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tile_t rom_fn(input logic [7:0] c, input logic [3:0] r);
        return c[2:0] ^ r[2:0];
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_col, bus.rom_row);

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic read(input int r, input int c, output int pix, output int cl);
        bus.pix_row = 4'(r);
        bus.pix_col = 5'(c);
        bus.cl_row  = 4'(r);
        bus.cl_col  = 5'(c);
        #1;
        pix = int'(bus.pix_tile);
        cl  = int'(bus.cl_tile);
    endtask

    // Every logical column c must hold ROM column view+c (or empty after reset).
    task automatic check_map(input int view, input logic cleared);
        int pix, cl, exp;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read(r, c, pix, cl);
                exp = cleared ? 0 : int'(rom_fn(8'(view + c), 4'(r)));
                check($sformatf("pix_r%0d_c%0d", r, c), pix, exp);
                check($sformatf("cl_r%0d_c%0d", r, c), cl, exp);
            end
    endtask

    task automatic do_op(input logic ls, input logic sr, input int dup_at);
        exp_t e;
        int busy_n, ack_at, acks;
        if (ls) begin
            e = '{busy_n: 301, ack_at: 0, acks: 0, view: 0};
            model_view = 0;
        end else if (model_view == LEVEL_COLS - COLS) begin
            e = '{busy_n: 1, ack_at: 1, acks: 1, view: model_view};
        end else begin
            model_view++;
            e = '{busy_n: 17, ack_at: 17, acks: 1, view: model_view};
        end
        sb_q.push_back(e);
        @(negedge clk);
        bus.load_start = ls;
        bus.scroll_req = sr;
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.scroll_req = 1'b0;
        busy_n = 0;
        ack_at = 0;
        acks   = 0;
        while (bus.busy && busy_n < 1000) begin
            busy_n++;
            if (bus.scroll_ack) begin
                acks++;
                ack_at = busy_n;
            end
            bus.scroll_req = (busy_n == dup_at);
            @(negedge clk);
        end
        bus.scroll_req = 1'b0;
        e = sb_q.pop_front();
        check("busy_cycles", busy_n, e.busy_n);
        check("ack_cycle", ack_at, e.ack_at);
        check("ack_count", acks, e.acks);
        check("view_col", int'(bus.view_col), e.view);
        check("head", int'(dut.head_q), e.view % COLS);
        check("at_end", int'(bus.at_end), int'(e.view == LEVEL_COLS - COLS));
    endtask

    initial begin
        int pix, cl, acks;
        checks = 0;
        errors = 0;
        model_view = 0;
        rst_n = 1'b0;
        bus.load_start = 1'b0;
        bus.scroll_req = 1'b0;
        bus.pix_row = '0;
        bus.pix_col = '0;
        bus.cl_row = '0;
        bus.cl_col = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ack", int'(bus.scroll_ack), 0);
        check("rst_view", int'(bus.view_col), 0);
        check("rst_rom_col", int'(bus.rom_col), 0);
        check("rst_rom_row", int'(bus.rom_row), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a load abandons it and clears the map.
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        acks = 0;
        repeat (100) begin
            acks += int'(bus.scroll_ack);
            @(negedge clk);
        end
        check("midload_busy", int'(bus.busy), 1);
        read(3, 5, pix, cl);
        check("midload_written", pix, 6);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_view", int'(bus.view_col), 0);
        check("midrst_ack", int'(bus.scroll_ack) + acks, 0);
        check_map(0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b1, 1'b0, 0);
        read(3, 5, pix, cl);
        check("load_pix_3_5", pix, 6);
        check("load_cl_3_5", cl, 6);
        read(15, 0, pix, cl);
        check("oob_pix_15_0", pix, 7);
        check("oob_cl_15_0", cl, 7);
        read(0, 20, pix, cl);
        check("oob_pix_0_20", pix, 7);
        read(15, 31, pix, cl);
        check("oob_cl_15_31", cl, 7);
        check_map(0, 1'b0);

        do_op(1'b0, 1'b1, 0);
        read(2, 19, pix, cl);
        check("scroll_pix_2_19", pix, 6);
        check_map(1, 1'b0);

        repeat (24) do_op(1'b0, 1'b1, 0);
        check_map(25, 1'b0);

        while (model_view < LEVEL_COLS - COLS) do_op(1'b0, 1'b1, 0);
        check_map(LEVEL_COLS - COLS, 1'b0);
        do_op(1'b0, 1'b1, 0);
        do_op(1'b0, 1'b1, 0);
        check_map(LEVEL_COLS - COLS, 1'b0);

        // Simultaneous load and scroll: the load wins, no ack.
        do_op(1'b1, 1'b1, 0);
        check_map(0, 1'b0);

        // A scroll request while busy is dropped.
        do_op(1'b0, 1'b1, 5);
        repeat (3) @(negedge clk);
        check("dup_idle_busy", int'(bus.busy), 0);
        check("dup_view", int'(bus.view_col), 1);
        check_map(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tilemap_loader.md
# tilemap_loader

Writer side of the on-screen tile map: owns the 15×20 array of 3-bit tiles (32×32 px each) that the player/physics block and the renderer read. On `load_start` it fills the map from the level ROM. On `scroll_req` it replaces one column in a circular buffer, so the view advances one tile to the right. Two asynchronous read ports serve pixel lookup and collision lookup.

## Interface
- `ROWS`, 15, tile rows on screen
- `COLS`, 20, tile columns on screen
- `LEVEL_COLS`, 212, total level width in tiles
- `Clk` in 1: system clock
- `Reset_n` in 1: asynchronous, active-low reset
- `load_start` in 1: single-cycle pulse; full reload with view at level column 0
- `scroll_req` in 1: single-cycle pulse; advance view by one column
- `busy` out 1: high while a load or scroll is in progress
- `scroll_ack` out 1: single-cycle pulse when a scroll request completes
- `at_end` out 1: high when `view_col + COLS == LEVEL_COLS`
- `view_col` out 8: level column shown at screen column 0
- `rom_col` out 8, `rom_row` out 4: level ROM address
- `rom_data` in 3: ROM tile; valid 1 cycle after address
- `pix_row` in 4, `pix_col` in 5, `pix_tile` out 3: renderer port (DrawY[9:5], DrawX[9:5]), combinational
- `cl_row` in 4, `cl_col` in 5, `cl_tile` out 3: collision port, combinational

## Operation
- Storage is `tiles[ROWS][COLS]`, which is physical. Register `head` (5 b, range 0..19) holds the physical column of logical screen column 0.
- Read mapping: `phys = cl_col + head`. If `phys ≥ COLS`, subtract COLS.
- A row ≥ 15 or column ≥ 20 on either read port returns `TILE_SOLID` (3'b111).
- FSM states are IDLE, LOAD, SCROLL, and ACK.
- **IDLE**
  - `load_start` → LOAD with `head`=0, `view_col`=0, counters at col 0 and row 0.
  - `scroll_req` with `at_end`=0 → SCROLL, with the target physical column = `head` and the ROM column = `view_col + COLS`.
  - `scroll_req` with `at_end`=1 → ACK; nothing changes.
  - `load_start` and `scroll_req` in the same cycle: load wins and the scroll is dropped, with no ack.
- **LOAD**
  - Issues addresses col-major: col 0..19, row 0..14 within each col.
  - Writes `rom_data` one cycle later to `tiles[row_d][col_d]`, where `row_d`/`col_d` are the delayed address.
  - After the last write (row 14, col 19) → IDLE. No ack is given for a load.
- **SCROLL**
  - Issues rows 0..14 of the ROM column and writes each into physical column `head` one cycle later.
  - After the row-14 write, in the same clock edge: `head` = `head` + 1 mod 20, and `view_col` = `view_col` + 1. Then → ACK.
- **ACK**: `scroll_ack`=1 for one cycle → IDLE.
- Any `load_start` or `scroll_req` while `busy`=1 is ignored. There is no queueing.
- Rows of the column being overwritten return new data as soon as they are written. Callers issue `scroll_req` during vertical blank (16 cycles ≪ blank period).
- Reset values (asynchronous, while `Reset_n`=0):
  - all tiles `TILE_EMPTY` (3'b000)
  - `head`=0, `view_col`=0
  - `busy`=0, `scroll_ack`=0
  - `rom_col`=0, `rom_row`=0
  - state IDLE
- Reset mid-operation abandons the load/scroll entirely: map cleared, no ack.

## Timing
- `busy` rises the cycle after the accepted request. It stays high through the last write and through ACK.
- Load: 300 address cycles + 1 write-drain cycle = 301 cycles busy.
- Scroll: 15 + 1 = 16 cycles in SCROLL, then 1 in ACK. `scroll_ack` is asserted 17 cycles after the `scroll_req` edge.
- End-of-level scroll: `scroll_ack` one cycle after the request, `busy` high for that cycle only.
- Read ports have zero latency: a write at edge N is visible on the ports after edge N.
- `view_col` is an 8-bit unsigned; its maximum is `LEVEL_COLS − COLS` = 192. It never wraps.

## Structure
- `tile_pkg`:
  - `tile_t` (logic [2:0])
  - `TILE_EMPTY`, `TILE_SOLID`
  - `ROWS`, `COLS`
  - `loader_state_t` enum {IDLE, LOAD, SCROLL, ACK}
  - shared with the player/physics block and the renderer
- One sub-module, `level_rom`: synchronous 1-cycle read, address {col, row}, initialized from the level file. It is instantiated beside `tilemap_loader`, not inside it.

## Test plan
- **Reset clear:** assert `Reset_n`=0 mid-LOAD (cycle 100) → all reads return 0, `busy`=0, `view_col`=0, no `scroll_ack`.
- **Full load:** ROM model returns `col[2:0]^row[2:0]`; pulse `load_start` → `busy` for exactly 301 cycles. After that, `pix_tile` at (row 3, col 5) = 6, and the out-of-range read (15, 0) = 7.
- **Single scroll:** after the load, pulse `scroll_req` → `scroll_ack` at +17 cycles, `view_col`=1, `head`=1. Logical col 19, row 2 holds ROM col 20 (value 6). Logical col 0 holds ROM col 1.
- **Wrap:** 25 scrolls → `head`=5, `view_col`=25. Every logical column c matches ROM column 25+c on both ports.
- **End of level:** scroll to `view_col`=192 → `at_end`=1. Next `scroll_req` → ack after 1 cycle, and `view_col` stays at 192.
- **Collisions:**
  - `load_start` and `scroll_req` in the same cycle → LOAD only, no ack.
  - `scroll_req` while busy → ignored; exactly one ack.
